// File: rtl/str_escape_encoder.sv
// Streaming encoder turning raw byte strings into SystemVerilog string-literal
// text: opening quote, escaped body, closing quote. Bytes enter on a
// valid/ready stream; literal characters leave on a valid/ready stream.
module str_escape_encoder #(
  parameter bit USE_SV_ESCAPES = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] esc_count
);

  typedef enum logic [2:0] {
    IDLE,
    OPENQ,
    BODY,
    EMIT,
    CLOSEQ
  } state_t;

  localparam logic [7:0]       QUOTE   = 8'h22;
  localparam logic [7:0]       BSLASH  = 8'h5C;
  localparam logic [7:0]       ZERO_CH = 8'h30;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] seqBuf [4];
  logic [2:0] seqLen;
  logic [1:0] idx;
  logic [1:0] idxNext;
  logic       lastLatched;

  logic [7:0] encChar [4];
  logic [2:0] encLen;

  // Byte acceptance depends on the registered state alone.
  assign in_ready = (state == BODY);
  assign idxNext  = idx + 2'd1;

  // Translate the incoming byte into its 1-, 2- or 4-character literal form.
  always_comb begin
    encChar[0] = in_data;
    encChar[1] = 8'h00;
    encChar[2] = 8'h00;
    encChar[3] = 8'h00;
    encLen     = 3'd1;
    if (in_data == 8'h0A) begin
      encChar[0] = BSLASH;
      encChar[1] = 8'h6E;
      encLen     = 3'd2;
    end else if (in_data == 8'h09) begin
      encChar[0] = BSLASH;
      encChar[1] = 8'h74;
      encLen     = 3'd2;
    end else if (in_data == 8'h5C) begin
      encChar[0] = BSLASH;
      encChar[1] = BSLASH;
      encLen     = 3'd2;
    end else if (in_data == 8'h22) begin
      encChar[0] = BSLASH;
      encChar[1] = QUOTE;
      encLen     = 3'd2;
    end else if (USE_SV_ESCAPES && (in_data == 8'h07)) begin
      encChar[0] = BSLASH;
      encChar[1] = 8'h61;
      encLen     = 3'd2;
    end else if (USE_SV_ESCAPES && (in_data == 8'h0C)) begin
      encChar[0] = BSLASH;
      encChar[1] = 8'h66;
      encLen     = 3'd2;
    end else if (USE_SV_ESCAPES && (in_data == 8'h0B)) begin
      encChar[0] = BSLASH;
      encChar[1] = 8'h76;
      encLen     = 3'd2;
    end else if ((in_data < 8'h20) || (in_data >= 8'h7F)) begin
      encChar[0] = BSLASH;
      encChar[1] = ZERO_CH + {6'b0, in_data[7:6]};
      encChar[2] = ZERO_CH + {5'b0, in_data[5:3]};
      encChar[3] = ZERO_CH + {5'b0, in_data[2:0]};
      encLen     = 3'd4;
    end
  end

  // Framing FSM: quote, per-byte escape sequences, closing quote; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      idx         <= 2'd0;
      seqLen      <= 3'd1;
      lastLatched <= 1'b0;
      esc_count   <= '0;
      for (int i = 0; i < 4; i++) seqBuf[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= OPENQ;
            out_valid <= 1'b1;
            out_data  <= QUOTE;
            out_last  <= 1'b0;
          end
        end
        OPENQ: begin
          if (out_ready) begin
            state     <= BODY;
            out_valid <= 1'b0;
          end
        end
        BODY: begin
          if (in_valid) begin
            for (int i = 0; i < 4; i++) seqBuf[i] <= encChar[i];
            seqLen      <= encLen;
            lastLatched <= in_last;
            idx         <= 2'd0;
            out_valid   <= 1'b1;
            out_data    <= encChar[0];
            out_last    <= 1'b0;
            state       <= EMIT;
            if ((encLen != 3'd1) && (esc_count != CNT_MAX))
              esc_count <= esc_count + CNT_ONE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if ({1'b0, idx} == (seqLen - 3'd1)) begin
              if (lastLatched) begin
                state     <= CLOSEQ;
                out_valid <= 1'b1;
                out_data  <= QUOTE;
                out_last  <= 1'b1;
              end else begin
                state     <= BODY;
                out_valid <= 1'b0;
              end
            end else begin
              idx      <= idxNext;
              out_data <= seqBuf[idxNext];
            end
          end
        end
        CLOSEQ: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_str_escape_encoder.sv
// Directed bench for str_escape_encoder: three instances cover the default
// build, the octal-only build and a 2-bit saturating escape counter.
module tb_str_escape_encoder;

  logic       clk;
  logic       rst_n;
  logic       inValid  [3];
  logic       inReady  [3];
  logic [7:0] inData   [3];
  logic       inLast   [3];
  logic       outValid [3];
  logic       outReady [3];
  logic [7:0] outData  [3];
  logic       outLast  [3];
  logic [15:0] escA;
  logic [15:0] escB;
  logic [1:0]  escC;

  int checks;
  int failures;

  logic [7:0] txQ [$];
  logic [7:0] expQ [$];
  logic [7:0] got [$];
  bit         readyPat [$];

  str_escape_encoder #(.USE_SV_ESCAPES(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]), .in_last(inLast[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]), .out_last(outLast[0]),
    .esc_count(escA)
  );

  str_escape_encoder #(.USE_SV_ESCAPES(1'b0), .CNT_W(16)) dutOct (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]), .in_last(inLast[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]), .out_last(outLast[1]),
    .esc_count(escB)
  );

  str_escape_encoder #(.USE_SV_ESCAPES(1'b1), .CNT_W(2)) dutSat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_data(inData[2]), .in_last(inLast[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_data(outData[2]), .out_last(outLast[2]),
    .esc_count(escC)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Push txQ through instance sel, collecting characters into got and checking
  // framing, stalls and in_ready on the way; expQ holds the required text.
  // A non-negative abortChar returns early when that character is presented.
  task automatic applyStimulus(input string tag, input int sel, input int abortChar);
    int         i;
    int         cyc;
    bit         done;
    bit         aborted;
    bit         prevStall;
    logic [7:0] prevData;
    logic       prevLast;
    bit         inHs;
    bit         outHs;
    bit         expLast;
    i         = 0;
    cyc       = 0;
    done      = 0;
    aborted   = 0;
    prevStall = 0;
    prevData  = 8'h00;
    prevLast  = 1'b0;
    got.delete();
    while (!done && !aborted && cyc < 300) begin
      if (i < txQ.size()) begin
        inValid[sel] = 1'b1;
        inData[sel]  = txQ[i];
        inLast[sel]  = (i == txQ.size() - 1);
      end else begin
        inValid[sel] = 1'b0;
        inData[sel]  = 8'h00;
        inLast[sel]  = 1'b0;
      end
      outReady[sel] = (readyPat.size() == 0) ? 1'b1 : readyPat[cyc % readyPat.size()];
      #1;
      if (prevStall) begin
        checkOutput({tag, "_stallValid"}, {31'b0, outValid[sel]}, 32'd1);
        checkOutput({tag, "_stallData"}, {24'b0, outData[sel]}, {24'b0, prevData});
        checkOutput({tag, "_stallLast"}, {31'b0, outLast[sel]}, {31'b0, prevLast});
      end
      if (outValid[sel])
        checkOutput({tag, "_inReadyLow"}, {31'b0, inReady[sel]}, 32'd0);
      if ((abortChar >= 0) && outValid[sel] && (outData[sel] == abortChar[7:0])) begin
        aborted = 1;
      end else begin
        inHs  = inValid[sel] && inReady[sel];
        outHs = outValid[sel] && outReady[sel];
        if (outHs) begin
          expLast = (got.size() == expQ.size() - 1);
          checkOutput($sformatf("%s_last%0d", tag, got.size()), {31'b0, outLast[sel]}, {31'b0, expLast});
          got.push_back(outData[sel]);
          if (outLast[sel]) done = 1;
        end
        prevStall = outValid[sel] && !outReady[sel];
        prevData  = outData[sel];
        prevLast  = outLast[sel];
        @(posedge clk);
        if (inHs) i++;
        @(negedge clk);
        cyc++;
      end
    end
    inValid[sel] = 1'b0;
    if (!aborted) begin
      checkOutput({tag, "_finished"}, {31'b0, done}, 32'd1);
      checkOutput({tag, "_len"}, got.size(), expQ.size());
    end
    for (int k = 0; k < got.size() && k < expQ.size(); k++)
      checkOutput($sformatf("%s_char%0d", tag, k), {24'b0, got[k]}, {24'b0, expQ[k]});
  endtask

  // Linear sequence of directed steps with hand-computed expected text.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int s = 0; s < 3; s++) begin
      inValid[s]  = 1'b0;
      inData[s]   = 8'h00;
      inLast[s]   = 1'b0;
      outReady[s] = 1'b1;
    end
    readyPat.delete();
    repeat (3) @(negedge clk);
    checkOutput("rst_outValid", {31'b0, outValid[0]}, 32'd0);
    checkOutput("rst_outData", {24'b0, outData[0]}, 32'd0);
    checkOutput("rst_outLast", {31'b0, outLast[0]}, 32'd0);
    checkOutput("rst_inReady", {31'b0, inReady[0]}, 32'd0);
    checkOutput("rst_esc", {16'b0, escA}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");

    txQ  = '{8'h41, 8'h0A};
    expQ = '{8'h22, 8'h41, 8'h5C, 8'h6E, 8'h22};
    applyStimulus("aNewline", 0, -1);
    checkOutput("aNewline_esc", {16'b0, escA}, 32'd1);

    txQ  = '{8'h00};
    expQ = '{8'h22, 8'h5C, 8'h30, 8'h30, 8'h30, 8'h22};
    applyStimulus("nul", 0, -1);
    txQ  = '{8'hFF};
    expQ = '{8'h22, 8'h5C, 8'h33, 8'h37, 8'h37, 8'h22};
    applyStimulus("ff", 0, -1);
    checkOutput("octal_esc", {16'b0, escA}, 32'd3);

    txQ  = '{8'h07};
    expQ = '{8'h22, 8'h5C, 8'h61, 8'h22};
    applyStimulus("bellSv", 0, -1);
    checkOutput("bellSv_esc", {16'b0, escA}, 32'd4);

    expQ = '{8'h22, 8'h5C, 8'h30, 8'h30, 8'h37, 8'h22};
    applyStimulus("bellOct", 1, -1);
    checkOutput("bellOct_esc", {16'b0, escB}, 32'd1);

    txQ  = '{8'h0C, 8'h0B};
    expQ = '{8'h22, 8'h5C, 8'h30, 8'h31, 8'h34, 8'h5C, 8'h30, 8'h31, 8'h33, 8'h22};
    applyStimulus("ffVtOct", 1, -1);
    checkOutput("ffVtOct_esc", {16'b0, escB}, 32'd3);

    txQ  = '{8'h0C, 8'h0B, 8'h7E, 8'h7F, 8'h20};
    expQ = '{8'h22, 8'h5C, 8'h66, 8'h5C, 8'h76, 8'h7E, 8'h5C, 8'h31, 8'h37, 8'h37, 8'h20, 8'h22};
    applyStimulus("mixed", 0, -1);
    checkOutput("mixed_esc", {16'b0, escA}, 32'd7);

    readyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
    txQ  = '{8'h22, 8'h5C};
    expQ = '{8'h22, 8'h5C, 8'h22, 8'h5C, 8'h5C, 8'h22};
    applyStimulus("stall", 0, -1);
    checkOutput("stall_esc", {16'b0, escA}, 32'd9);
    readyPat.delete();

    txQ  = '{8'h1F};
    expQ = '{8'h22, 8'h5C, 8'h30, 8'h33, 8'h37, 8'h22};
    applyStimulus("abort", 0, 8'h33);
    checkOutput("abort_seen", {16'b0, escA}, 32'd10);
    checkOutput("abort_midValid", {31'b0, outValid[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outValid", {31'b0, outValid[0]}, 32'd0);
    checkOutput("abort_outData", {24'b0, outData[0]}, 32'd0);
    checkOutput("abort_outLast", {31'b0, outLast[0]}, 32'd0);
    checkOutput("abort_inReady", {31'b0, inReady[0]}, 32'd0);
    checkOutput("abort_esc", {16'b0, escA}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRst_idle", {31'b0, outValid[0]}, 32'd0);
    txQ  = '{8'h62};
    expQ = '{8'h22, 8'h62, 8'h22};
    applyStimulus("postRst", 0, -1);
    checkOutput("postRst_esc", {16'b0, escA}, 32'd0);

    txQ  = '{8'h09, 8'h09};
    expQ = '{8'h22, 8'h5C, 8'h74, 8'h5C, 8'h74, 8'h22};
    applyStimulus("satTwo", 2, -1);
    checkOutput("satTwo_esc", {30'b0, escC}, 32'd2);

    txQ.delete();
    expQ.delete();
    expQ.push_back(8'h22);
    for (int b = 0; b < 7; b++) begin
      txQ.push_back(8'h09);
      expQ.push_back(8'h5C);
      expQ.push_back(8'h74);
    end
    expQ.push_back(8'h22);
    applyStimulus("satSeven", 2, -1);
    checkOutput("satSeven_esc", {30'b0, escC}, 32'd3);

    txQ  = '{8'h09};
    expQ = '{8'h22, 8'h5C, 8'h74, 8'h22};
    applyStimulus("satHold", 2, -1);
    checkOutput("satHold_esc", {30'b0, escC}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
